mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// fixed-latency memory, with round-robin arbitration when both ask at once.
module mem_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int LATENCY   = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 IReq,
   input  logic [WORD_SIZE-1:0] IAddr,
   output logic                 IReady,
   output logic [WORD_SIZE-1:0] IData,
   input  logic                 DReq,
   input  logic                 DWrite,
   input  logic [WORD_SIZE-1:0] DAddr,
   input  logic [WORD_SIZE-1:0] DWData,
   output logic                 DReady,
   output logic [WORD_SIZE-1:0] DRData,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [WORD_SIZE-1:0] MemAddr,
   output logic [WORD_SIZE-1:0] MemWData,
   input  logic [WORD_SIZE-1:0] MemRData,
   output logic [1:0]           dbg_state
);

   // Handshake: a requester raises Req with its address/data and holds it until
   // its Ready pulses; the arbiter samples the request only at the grant edge and
   // a port whose Ready is high in the current cycle cannot be granted again.

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_I_ACCESS = 2'd1,
      ST_D_ACCESS = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 last_d_q, last_d_d;
   logic                 write_q, write_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic                 i_ready_q, i_ready_d;
   logic                 d_ready_q, d_ready_d;
   logic [WORD_SIZE-1:0] i_data_q, i_data_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 i_elig;
   logic                 d_elig;

   assign i_elig = IReq & ~i_ready_q;
   assign d_elig = DReq & ~d_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d_d    = last_d_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_data_d    = i_data_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         ST_IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            // D wins a tie unless D was the most recently completed grant.
            if (d_elig && (!i_elig || !last_d_q)) begin
               state_d     = ST_D_ACCESS;
               cnt_d       = 4'd0;
               addr_d      = DAddr;
               wdata_d     = DWData;
               write_d     = DWrite;
               mem_read_d  = ~DWrite;
               mem_write_d = DWrite;
            end else if (i_elig) begin
               state_d     = ST_I_ACCESS;
               cnt_d       = 4'd0;
               addr_d      = IAddr;
               write_d     = 1'b0;
               mem_read_d  = 1'b1;
            end
         end
         ST_I_ACCESS, ST_D_ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d     = ST_IDLE;
               cnt_d       = 4'd0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               last_d_d    = (state_q == ST_D_ACCESS);
               if (state_q == ST_I_ACCESS) begin
                  i_ready_d = 1'b1;
                  i_data_d  = MemRData;
               end else begin
                  d_ready_d = 1'b1;
                  if (!write_q) begin
                     d_rdata_d = MemRData;
                  end
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         last_d_q    <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_data_q    <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_d_q    <= last_d_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_data_q    <= i_data_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign IReady    = i_ready_q;
   assign IData     = i_data_q;
   assign DReady    = d_ready_q;
   assign DRData    = d_rdata_q;
   assign MemRead   = mem_read_q;
   assign MemWrite  = mem_write_q;
   assign MemAddr   = addr_q;
   assign MemWData  = wdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, contention and reset sequences,
// a LATENCY=1 instance, and random traffic against a transaction timeline model.
module tb_mem_arbiter;

   localparam int W   = 16;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ireq, dreq, dwrite;
   logic [W-1:0] iaddr, daddr, dwdata;
   logic         i_ready, d_ready, mem_read, mem_write;
   logic [W-1:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]   dbg_state;

   logic         l1_dreq, l1_dwrite, l1_ireq;
   logic [W-1:0] l1_daddr, l1_dwdata, l1_iaddr;
   logic         l1_i_ready, l1_d_ready, l1_mem_read, l1_mem_write;
   logic [W-1:0] l1_i_data, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
   logic [1:0]   l1_dbg_state;

   logic [W-1:0] mem_arr [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_rdata    = mem_arr[mem_addr[7:0]];
   assign l1_mem_rdata = mem_arr[l1_mem_addr[7:0]];

   mem_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
      .Clk(clk), .Reset(rst),
      .IReq(ireq), .IAddr(iaddr), .IReady(i_ready), .IData(i_data),
      .DReq(dreq), .DWrite(dwrite), .DAddr(daddr), .DWData(dwdata),
      .DReady(d_ready), .DRData(d_rdata),
      .MemRead(mem_read), .MemWrite(mem_write), .MemAddr(mem_addr),
      .MemWData(mem_wdata), .MemRData(mem_rdata), .dbg_state(dbg_state)
   );

   mem_arbiter #(.WORD_SIZE(W), .LATENCY(1)) dut1 (
      .Clk(clk), .Reset(rst),
      .IReq(l1_ireq), .IAddr(l1_iaddr), .IReady(l1_i_ready), .IData(l1_i_data),
      .DReq(l1_dreq), .DWrite(l1_dwrite), .DAddr(l1_daddr), .DWData(l1_dwdata),
      .DReady(l1_d_ready), .DRData(l1_d_rdata),
      .MemRead(l1_mem_read), .MemWrite(l1_mem_write), .MemAddr(l1_mem_addr),
      .MemWData(l1_mem_wdata), .MemRData(l1_mem_rdata), .dbg_state(l1_dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      logic         is_d;
      logic         wr;
      logic [W-1:0] addr;
      logic [W-1:0] rdata;
      int           done_e;
   } txn_t;

   txn_t         exp_q[$];
   int           edge_n;
   int           m_done_e;
   logic         m_done_d, m_last_d, m_ir, m_dr;
   logic [W-1:0] m_addr, m_wdata, m_idata, m_drdata;

   function automatic logic [67:0] mk_exp(input logic mr, input logic mw,
                                          input logic ir, input logic dr,
                                          input logic [W-1:0] a, input logic [W-1:0] wd,
                                          input logic [W-1:0] id, input logic [W-1:0] dd);
      return {mr, mw, ir, dr, a, wd, id, dd};
   endfunction

   task automatic check_vec(input string name, input logic [67:0] exp_v);
      logic [67:0] act_v;
      act_v = {mem_read, mem_write, i_ready, d_ready, mem_addr, mem_wdata, i_data, d_rdata};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      edge_n   = 0;
      m_done_e = -10;
      m_done_d = 1'b0;
      m_last_d = 1'b0;
      m_ir     = 1'b0;
      m_dr     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_idata  = '0;
      m_drdata = '0;
   endtask

   // Timeline view: a grant at edge e keeps the memory busy through edge e+LAT,
   // where Ready is produced; the just-completed port sits out the next edge.
   task automatic model_edge();
      txn_t t;
      logic i_elig, d_elig;
      m_ir = 1'b0;
      m_dr = 1'b0;
      if (exp_q.size() != 0) begin
         if (exp_q[0].done_e == edge_n) begin
            t = exp_q.pop_front();
            if (t.is_d) begin
               m_dr = 1'b1;
               if (!t.wr) m_drdata = t.rdata;
            end else begin
               m_ir    = 1'b1;
               m_idata = t.rdata;
            end
            m_last_d = t.is_d;
            m_done_d = t.is_d;
            m_done_e = edge_n;
         end
      end else begin
         i_elig = ireq && !(m_done_e == edge_n - 1 && !m_done_d);
         d_elig = dreq && !(m_done_e == edge_n - 1 && m_done_d);
         if (i_elig || d_elig) begin
            t.is_d   = d_elig && !(i_elig && m_last_d);
            t.wr     = t.is_d && dwrite;
            t.addr   = t.is_d ? daddr : iaddr;
            t.rdata  = mem_arr[t.addr[7:0]];
            t.done_e = edge_n + LAT;
            m_addr   = t.addr;
            if (t.is_d) m_wdata = dwdata;
            exp_q.push_back(t);
         end
      end
      edge_n++;
   endtask

   task automatic cycle_step(input string name);
      logic mr, mw;
      model_edge();
      @(posedge clk);
      #1;
      mr = (exp_q.size() != 0) && !exp_q[0].wr;
      mw = (exp_q.size() != 0) && exp_q[0].wr;
      check_vec(name, mk_exp(mr, mw, m_ir, m_dr, m_addr, m_wdata, m_idata, m_drdata));
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      ireq = 1'b0; dreq = 1'b0; dwrite = 1'b0;
      iaddr = '0; daddr = '0; dwdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   logic [3:0] order_v;

   task automatic run_pair(input logic [W-1:0] ia, input logic [W-1:0] da);
      int n;
      n = 0;
      ireq = 1'b1; iaddr = ia;
      dreq = 1'b1; daddr = da; dwrite = 1'b0; dwdata = 16'h0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         cycle_step("pair");
         if (d_ready) begin order_v = {order_v[2:0], 1'b1}; dreq = 1'b0; n++; end
         if (i_ready) begin order_v = {order_v[2:0], 1'b0}; ireq = 1'b0; n++; end
      end
      if (n < 2) begin
         checks++;
         errors++;
         $display("FAIL pair_timeout: got %0d completions expected 2", n);
      end
      cycle_step("pair_idle");
   endtask

   typedef struct {
      logic         ireq;
      logic [W-1:0] iaddr;
      logic         dreq;
      logic         dwrite;
      logic [W-1:0] daddr;
      logic [W-1:0] dwdata;
      logic [67:0]  exp_v;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int lat_cnt;
      logic got;

      rst = 1'b1;
      l1_ireq = 1'b0; l1_iaddr = '0; l1_dreq = 1'b0; l1_dwrite = 1'b0;
      l1_daddr = '0; l1_dwdata = '0;
      for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
      mem_arr[8'h10] = 16'hABCD;
      mem_arr[8'h20] = 16'h5555;
      mem_arr[8'h30] = 16'h7777;
      mem_arr[8'h01] = 16'h1111;
      mem_arr[8'h02] = 16'h2222;
      mem_arr[8'h50] = 16'h5A5A;

      // fetch, store, held-Req and dropped-Req read
      vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, mk_exp(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000)};
      vecs[1]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, mk_exp(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000)};
      vecs[2]  = vecs[1];
      vecs[3]  = vecs[1];
      vecs[4]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, mk_exp(0, 0, 1, 0, 16'h0010, 16'h0000, 16'hABCD, 16'h0000)};
      vecs[5]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, mk_exp(0, 0, 0, 0, 16'h0010, 16'h0000, 16'hABCD, 16'h0000)};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, mk_exp(0, 1, 0, 0, 16'h0020, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'hDEAD, mk_exp(0, 1, 0, 0, 16'h0020, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[8]  = vecs[7];
      vecs[9]  = vecs[7];
      vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'hDEAD, mk_exp(0, 0, 0, 1, 16'h0020, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h1234, mk_exp(0, 0, 0, 0, 16'h0020, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h1234, mk_exp(1, 0, 0, 0, 16'h0030, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'h1234, mk_exp(1, 0, 0, 0, 16'h0030, 16'h1234, 16'hABCD, 16'h0000)};
      vecs[14] = vecs[13];
      vecs[15] = vecs[13];
      vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'h1234, mk_exp(0, 0, 0, 1, 16'h0030, 16'h1234, 16'hABCD, 16'h7777)};
      vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'h1234, mk_exp(0, 0, 0, 0, 16'h0030, 16'h1234, 16'hABCD, 16'h7777)};

      // ---- reset state ----
      do_reset();
      check_vec("reset_outputs", 68'h0);
      check_val("reset_state", 64'(dbg_state), 64'h0);

      // ---- directed vector table ----
      for (int i = 0; i < 18; i++) begin
         ireq = vecs[i].ireq; iaddr = vecs[i].iaddr;
         dreq = vecs[i].dreq; dwrite = vecs[i].dwrite;
         daddr = vecs[i].daddr; dwdata = vecs[i].dwdata;
         @(posedge clk);
         #1;
         check_vec($sformatf("vec%0d", i), vecs[i].exp_v);
      end

      // ---- contention from reset: D, I, then D, I ----
      do_reset();
      order_v = 4'h0;
      run_pair(16'h0040, 16'h0041);
      run_pair(16'h0042, 16'h0043);
      check_val("rr_order", 64'(order_v), 64'hA);

      // ---- reset during access cycle 2 ----
      do_reset();
      ireq = 1'b1; iaddr = 16'h0050;
      cycle_step("abort_grant");
      cycle_step("abort_acc1");
      rst = 1'b1;
      #1;
      check_vec("abort_async", 68'h0);
      check_val("abort_state", 64'(dbg_state), 64'h0);
      got = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         got = got | i_ready;
      end
      check_val("abort_no_ready", 64'(got), 64'h0);
      rst = 1'b0;
      model_reset();
      lat_cnt = 0;
      for (int c = 0; c < 20 && !i_ready; c++) begin
         cycle_step("abort_retry");
         lat_cnt++;
      end
      ireq = 1'b0;
      check_val("abort_retry_latency", 64'(lat_cnt), 64'(LAT + 1));
      check_val("abort_retry_data", 64'(i_data), 64'h5A5A);
      cycle_step("abort_idle");

      // ---- LATENCY=1 back-to-back D reads ----
      l1_dreq = 1'b1; l1_dwrite = 1'b0; l1_daddr = 16'h0001;
      @(posedge clk); #1;
      check_val("l1_grant1", {29'h0, l1_mem_read, l1_mem_write, l1_d_ready, l1_mem_addr, l1_d_rdata},
                {29'h0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000});
      @(posedge clk); #1;
      check_val("l1_ready1", {29'h0, l1_mem_read, l1_mem_write, l1_d_ready, l1_mem_addr, l1_d_rdata},
                {29'h0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h1111});
      l1_daddr = 16'h0002;
      @(posedge clk); #1;
      check_val("l1_gap", {29'h0, l1_mem_read, l1_mem_write, l1_d_ready, l1_mem_addr, l1_d_rdata},
                {29'h0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h1111});
      @(posedge clk); #1;
      check_val("l1_grant2", {29'h0, l1_mem_read, l1_mem_write, l1_d_ready, l1_mem_addr, l1_d_rdata},
                {29'h0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1111});
      @(posedge clk); #1;
      l1_dreq = 1'b0;
      check_val("l1_ready2", {29'h0, l1_mem_read, l1_mem_write, l1_d_ready, l1_mem_addr, l1_d_rdata},
                {29'h0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h2222});
      check_val("l1_state", 64'(l1_dbg_state), 64'h0);

      // ---- random traffic ----
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (!ireq) begin
            if ($urandom_range(0, 2) == 0) ireq = 1'b1;
         end else if (i_ready) begin
            if ($urandom_range(0, 3) != 0) ireq = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            ireq = 1'b0;
         end
         if (!dreq) begin
            if ($urandom_range(0, 2) == 0) dreq = 1'b1;
         end else if (d_ready) begin
            if ($urandom_range(0, 3) != 0) dreq = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            dreq = 1'b0;
         end
         iaddr  = 16'($urandom);
         daddr  = 16'($urandom);
         dwdata = 16'($urandom);
         dwrite = 1'($urandom_range(0, 1));
         cycle_step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
